dlx_alu_issue: RTL and testbench
================================

DLX_ALU_ISSUE -- requirements
Module: dlx_alu_issue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width; only 32 supported.
REQ-002 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1: instruction handshake; transfer when both are 1.
REQ-005 SHALL have ports in_instr input 32 (DLX word), in_rs1_val input 32, in_rs2_val input 32: register-file operands, sampled with the instruction.
REQ-006 SHALL have ports alu_op output 4, alu_ex output 1, alu_op1 output 32, alu_op2 output 32: drive the ALU opcode, execute enable and operands.
REQ-007 SHALL have ports alu_res input 32, alu_carry input 1, alu_z input 1: the ALU's registered result and flags.
REQ-008 SHALL have ports wb_valid output 1, wb_ready input 1, wb_rd output 5, wb_data output 32, wb_carry output 1, wb_z output 1: writeback handshake.
REQ-009 SHALL have port illegal output 1: one-cycle pulse on an unsupported instruction.

Function
REQ-010 SHALL decode R-type (opcode 6'h00; rs1=[25:21], rs2=[20:16], rd=[15:11]) by func: ADD 20h->1, SUB 22h->2, AND 24h->3, OR 25h->4, XOR 26h->5, SLL 04h->6, SRL 06h->7, SEQ 28h->10, SLE 2Ch->11, SLT 2Ah->12, SNE 29h->13.
REQ-011 SHALL decode I-type (rs1=[25:21], rd=[20:16], imm=[15:0]) by opcode: ADDI 08h, SUBI 0Ah, ANDI 0Ch, ORI 0Dh, XORI 0Eh, SLLI 14h, SRLI 16h, SEQI 18h, SNEI 19h, SLTI 1Ah, SLEI 1Ch, mapping to the same ALU codes as their R-type forms.
REQ-012 SHALL sign-extend imm for ADDI/SUBI/SEQI/SNEI/SLTI/SLEI and zero-extend it for ANDI/ORI/XORI/SLLI/SRLI; alu_op2 = extended imm (I-type) or rs2 value (R-type).
REQ-013 SHALL use FSM states IDLE, ISSUE, WAIT, WB; in_ready=1 only in IDLE.
REQ-014 IDLE: on handshake with a legal instruction, latch op, operands and rd, go to ISSUE; with an illegal instruction, pulse illegal next cycle and stay in IDLE.
REQ-015 ISSUE: assert alu_ex=1 for exactly one cycle with latched alu_op/op1/op2, then go to WAIT.
REQ-016 WAIT: capture alu_res into wb_data, alu_z into wb_z, and alu_carry into wb_carry (forced 0 unless op is ADD/SUB); go to WB if rd!=0, otherwise to IDLE with no writeback.
REQ-017 WB: hold wb_valid=1 and all wb_* stable until wb_ready=1, then go to IDLE in the same cycle wb_valid drops.
REQ-018 Latency SHALL be: accept at cycle N, alu_ex at N+1, wb_valid at N+3, next in_ready at N+4 with wb_ready held 1.
REQ-019 alu_ex SHALL be 0 in all states except ISSUE; alu_op/op1/op2 SHALL hold their last latched value outside ISSUE.
REQ-020 Only one instruction SHALL be in flight; no new instruction is accepted before WB completes.

Reset
REQ-021 On rst, state SHALL become IDLE immediately and hold until release.
REQ-022 On rst, outputs SHALL reset to: in_ready=1 after release, alu_ex=0, alu_op=0, alu_op1=0, alu_op2=0, wb_valid=0, wb_rd=0, wb_data=0, wb_carry=0, wb_z=0, illegal=0.
REQ-023 Reset mid-operation SHALL discard the in-flight instruction with no wb_valid pulse.

Structure
REQ-024 Shared package dlx_pkg SHALL hold the ALU opcode enum (codes 1-13), the DLX opcode/func constants, and the FSM state enum.
REQ-025 Combinational decode (instr -> alu_op, rd, imm-extension, legal) SHALL be one sub-module, dlx_alu_decode.

Verification
REQ-026 ADD R-type rd=3, rs1=7FFFFFFFh, rs2=1 -> one alu_ex pulse, wb_rd=3, wb_data=80000000h, wb_carry=0, wb_z=0 at N+3.
REQ-027 SUBI rd=5, rs1=0, imm=0001h -> wb_data=FFFFFFFFh, wb_carry=1; ANDI imm=8000h -> op2=00008000h (zero-extended).
REQ-028 SEQ rs1=rs2=1234h, rd=0 -> ALU issued, no wb_valid, in_ready back at N+3.
REQ-029 Opcode 3Fh -> illegal=1 for one cycle, alu_ex never asserted, in_ready stays 1.
REQ-030 XOR rs1=rs2=A5A5A5A5h with wb_ready=0 for 5 cycles -> wb_valid with wb_data=0, wb_z=1 held stable, in_ready=0 throughout.
REQ-031 rst asserted during WAIT -> immediate IDLE, all outputs at reset values, no writeback for that instruction.

Source files
------------

// File: rtl/dlx_pkg.sv
// dlx_pkg: shared ALU opcodes, DLX opcode/func constants and issue FSM states.
package dlx_pkg;
  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SEQ = 4'd10,
    ALU_SLE = 4'd11,
    ALU_SLT = 4'd12,
    ALU_SNE = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SUBI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_SLLI = 6'h14;
  localparam logic [5:0] OP_SRLI = 6'h16;
  localparam logic [5:0] OP_SEQI = 6'h18;
  localparam logic [5:0] OP_SNEI = 6'h19;
  localparam logic [5:0] OP_SLTI = 6'h1A;
  localparam logic [5:0] OP_SLEI = 6'h1C;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_SLL = 6'h04;
  localparam logic [5:0] F_SRL = 6'h06;
  localparam logic [5:0] F_SEQ = 6'h28;
  localparam logic [5:0] F_SLE = 6'h2C;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_SNE = 6'h29;
endpackage

// File: rtl/dlx_alu_decode.sv
// dlx_alu_decode: combinational DLX instruction decode to ALU op, rd and operand-2 source.
module dlx_alu_decode
  import dlx_pkg::*;
(
  input  logic [31:0] instr,
  output alu_op_e     op,
  output logic [4:0]  rd,
  output logic [31:0] imm_ext,
  output logic        use_imm,
  output logic        legal
);
  logic [5:0] opc, func;
  logic sx;
  assign opc = instr[31:26];
  assign func = instr[5:0];
  always_comb begin
    op = ALU_NOP;
    sx = 1'b0;
    use_imm = opc != OP_R;
    if (opc == OP_R) begin
      case (func)
        F_ADD: op = ALU_ADD;
        F_SUB: op = ALU_SUB;
        F_AND: op = ALU_AND;
        F_OR:  op = ALU_OR;
        F_XOR: op = ALU_XOR;
        F_SLL: op = ALU_SLL;
        F_SRL: op = ALU_SRL;
        F_SEQ: op = ALU_SEQ;
        F_SLE: op = ALU_SLE;
        F_SLT: op = ALU_SLT;
        F_SNE: op = ALU_SNE;
        default: op = ALU_NOP;
      endcase
    end else begin
      // arithmetic and compare immediates are signed, logic and shift immediates are not
      case (opc)
        OP_ADDI: begin op = ALU_ADD; sx = 1'b1; end
        OP_SUBI: begin op = ALU_SUB; sx = 1'b1; end
        OP_ANDI: op = ALU_AND;
        OP_ORI:  op = ALU_OR;
        OP_XORI: op = ALU_XOR;
        OP_SLLI: op = ALU_SLL;
        OP_SRLI: op = ALU_SRL;
        OP_SEQI: begin op = ALU_SEQ; sx = 1'b1; end
        OP_SNEI: begin op = ALU_SNE; sx = 1'b1; end
        OP_SLTI: begin op = ALU_SLT; sx = 1'b1; end
        OP_SLEI: begin op = ALU_SLE; sx = 1'b1; end
        default: op = ALU_NOP;
      endcase
    end
  end
  assign legal = op != ALU_NOP;
  assign rd = use_imm ? instr[20:16] : instr[15:11];
  assign imm_ext = sx ? {{16{instr[15]}}, instr[15:0]} : {16'h0, instr[15:0]};
endmodule

// File: rtl/dlx_alu_issue.sv
// dlx_alu_issue: single-issue DLX ALU sequencer (decode, issue, wait for result, writeback).
module dlx_alu_issue
  import dlx_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs1_val,
  input  logic [DATA_W-1:0] in_rs2_val,
  output logic [3:0]        alu_op,
  output logic              alu_ex,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_carry,
  input  logic              alu_z,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_carry,
  output logic              wb_z,
  output logic              illegal
);
  state_e state, next;
  alu_op_e dec_op;
  logic [4:0] dec_rd;
  logic [31:0] dec_imm;
  logic dec_use_imm, dec_legal, accept;

  dlx_alu_decode u_dec (
    .instr(in_instr),
    .op(dec_op),
    .rd(dec_rd),
    .imm_ext(dec_imm),
    .use_imm(dec_use_imm),
    .legal(dec_legal)
  );

  assign in_ready = state == IDLE;
  assign alu_ex = state == ISSUE;
  assign wb_valid = state == WB;
  assign accept = in_ready && in_valid;

  always_comb begin
    next = state;
    case (state)
      IDLE:  next = accept && dec_legal ? ISSUE : IDLE;
      ISSUE: next = WAIT;
      WAIT:  next = wb_rd != 5'd0 ? WB : IDLE;
      WB:    next = wb_ready ? IDLE : WB;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      alu_op <= 4'd0;
      alu_op1 <= '0;
      alu_op2 <= '0;
      wb_rd <= 5'd0;
      wb_data <= '0;
      wb_carry <= 1'b0;
      wb_z <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= next;
      illegal <= accept && !dec_legal;
      if (accept && dec_legal) begin
        alu_op <= dec_op;
        alu_op1 <= in_rs1_val;
        alu_op2 <= dec_use_imm ? dec_imm : in_rs2_val;
        wb_rd <= dec_rd;
      end
      // carry is only meaningful for add/subtract
      if (state == WAIT) begin
        wb_data <= alu_res;
        wb_z <= alu_z;
        wb_carry <= alu_carry && (alu_op == ALU_ADD || alu_op == ALU_SUB);
      end
    end
  end
endmodule

// File: tb/tb_dlx_alu_issue.sv
// tb_dlx_alu_issue: directed checks of the DLX ALU issue sequencer against a behavioural ALU.
module tb_dlx_alu_issue;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [31:0] in_instr = '0, in_rs1_val = '0, in_rs2_val = '0;
  logic [3:0] alu_op;
  logic alu_ex;
  logic [31:0] alu_op1, alu_op2;
  logic [31:0] alu_res = '0;
  logic alu_carry = 1'b0, alu_z = 1'b0;
  logic wb_valid, wb_ready = 1'b1;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  logic wb_carry, wb_z, illegal;
  int vectors = 0, errors = 0;
  int ex_count = 0;

  dlx_alu_issue #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .alu_op(alu_op), .alu_ex(alu_ex), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_res(alu_res), .alu_carry(alu_carry), .alu_z(alu_z),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_carry(wb_carry), .wb_z(wb_z), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Behavioural registered ALU driven by the sequencer; carry on SUB is the borrow.
  always @(posedge clk) begin
    if (alu_ex) begin
      logic [32:0] r;
      ex_count++;
      case (alu_op)
        4'd1:  r = {1'b0, alu_op1} + {1'b0, alu_op2};
        4'd2:  r = {1'b0, alu_op1} - {1'b0, alu_op2};
        4'd3:  r = {1'b0, alu_op1 & alu_op2};
        4'd4:  r = {1'b0, alu_op1 | alu_op2};
        4'd5:  r = {1'b0, alu_op1 ^ alu_op2};
        4'd6:  r = {1'b0, alu_op1 << alu_op2[4:0]};
        4'd7:  r = {1'b0, alu_op1 >> alu_op2[4:0]};
        4'd10: r = {32'd0, alu_op1 == alu_op2};
        4'd11: r = {32'd0, $signed(alu_op1) <= $signed(alu_op2)};
        4'd12: r = {32'd0, $signed(alu_op1) < $signed(alu_op2)};
        4'd13: r = {32'd0, alu_op1 != alu_op2};
        default: r = '0;
      endcase
      alu_res <= r[31:0];
      alu_carry <= r[32];
      alu_z <= r[31:0] == 32'd0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_instr = ins;
    in_rs1_val = a;
    in_rs2_val = b;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_alu_ex", {31'd0, alu_ex}, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    chk("rst_op1", alu_op1, 32'd0);
    chk("rst_op2", alu_op2, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // ADD r3 = r1 + r2 : latency N+1 issue, N+3 writeback, N+4 ready
    chk("add_ready", {31'd0, in_ready}, 32'd1);
    send({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'h7FFF_FFFF, 32'h1);
    chk("add_ex", {31'd0, alu_ex}, 32'd1);
    chk("add_op", {28'd0, alu_op}, 32'd1);
    chk("add_op1", alu_op1, 32'h7FFF_FFFF);
    chk("add_op2", alu_op2, 32'h1);
    chk("add_busy", {31'd0, in_ready}, 32'd0);
    step();
    chk("add_ex_off", {31'd0, alu_ex}, 32'd0);
    chk("add_wait_nowb", {31'd0, wb_valid}, 32'd0);
    step();
    chk("add_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("add_wb_rd", {27'd0, wb_rd}, 32'd3);
    chk("add_wb_data", wb_data, 32'h8000_0000);
    chk("add_wb_carry", {31'd0, wb_carry}, 32'd0);
    chk("add_wb_z", {31'd0, wb_z}, 32'd0);
    chk("add_ex_count", ex_count, 1);
    step();
    chk("add_done", {30'd0, wb_valid, in_ready}, 32'd1);

    // SUBI r5 = 0 - 1 : borrow reported as carry
    send({6'h0A, 5'd1, 5'd5, 16'h0001}, 32'h0, 32'hDEAD_BEEF);
    chk("subi_op", {28'd0, alu_op}, 32'd2);
    chk("subi_op2", alu_op2, 32'h1);
    step();
    step();
    chk("subi_wb_rd", {27'd0, wb_rd}, 32'd5);
    chk("subi_wb_data", wb_data, 32'hFFFF_FFFF);
    chk("subi_wb_carry", {31'd0, wb_carry}, 32'd1);
    step();

    // ANDI zero-extends; carry forced low for logic ops
    send({6'h0C, 5'd1, 5'd6, 16'h8000}, 32'hFFFF_FFFF, 32'h0);
    chk("andi_op", {28'd0, alu_op}, 32'd3);
    chk("andi_op2", alu_op2, 32'h0000_8000);
    step();
    step();
    chk("andi_wb_data", wb_data, 32'h0000_8000);
    chk("andi_wb_carry", {31'd0, wb_carry}, 32'd0);
    step();

    // SLTI sign-extends
    send({6'h1A, 5'd1, 5'd7, 16'hFFFF}, 32'hFFFF_FFFE, 32'h0);
    chk("slti_op", {28'd0, alu_op}, 32'd12);
    chk("slti_op2", alu_op2, 32'hFFFF_FFFF);
    step();
    step();
    chk("slti_wb_data", wb_data, 32'h1);
    step();

    // SEQ with rd=0: issued but never written back
    ex_count = 0;
    send({6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h28}, 32'h1234, 32'h1234);
    chk("seq_op", {28'd0, alu_op}, 32'd10);
    chk("seq_ex", {31'd0, alu_ex}, 32'd1);
    step();
    chk("seq_wait_nowb", {31'd0, wb_valid}, 32'd0);
    step();
    chk("seq_ready_n3", {31'd0, in_ready}, 32'd1);
    chk("seq_nowb", {31'd0, wb_valid}, 32'd0);
    chk("seq_ex_count", ex_count, 1);

    // Illegal opcode 3Fh: one-cycle pulse, nothing issued
    ex_count = 0;
    send({6'h3F, 26'h0}, 32'h5, 32'h6);
    chk("ill_pulse", {31'd0, illegal}, 32'd1);
    chk("ill_ready", {31'd0, in_ready}, 32'd1);
    chk("ill_no_ex", {31'd0, alu_ex}, 32'd0);
    step();
    chk("ill_pulse_end", {31'd0, illegal}, 32'd0);
    step();
    chk("ill_ex_count", ex_count, 0);
    chk("ill_still_ready", {31'd0, in_ready}, 32'd1);

    // XOR to zero with writeback stalled 5 cycles
    wb_ready = 1'b0;
    send({6'h00, 5'd1, 5'd2, 5'd9, 5'd0, 6'h26}, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("xor_hold_valid", {31'd0, wb_valid}, 32'd1);
      chk("xor_hold_data", wb_data, 32'h0);
      chk("xor_hold_z", {31'd0, wb_z}, 32'd1);
      chk("xor_hold_rd", {27'd0, wb_rd}, 32'd9);
      chk("xor_hold_busy", {31'd0, in_ready}, 32'd0);
    end
    wb_ready = 1'b1;
    #1;
    chk("xor_release_valid", {31'd0, wb_valid}, 32'd1);
    step();
    chk("xor_done", {30'd0, wb_valid, in_ready}, 32'd1);

    // Asynchronous reset during WAIT discards the instruction
    send({6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h20}, 32'h10, 32'h20);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_ex", {31'd0, alu_ex}, 32'd0);
    chk("arst_op", {28'd0, alu_op}, 32'd0);
    chk("arst_op1", alu_op1, 32'd0);
    chk("arst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("arst_wb_data", wb_data, 32'd0);
    chk("arst_wb_valid", {31'd0, wb_valid}, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("arst_no_wb", {31'd0, wb_valid}, 32'd0);
      chk("arst_idle", {31'd0, in_ready}, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
